stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
Multi-byte stack transaction controller for the 6502 core. It sequences 1–3 byte pushes and pulls (PHA/PHP, JSR, BRK/IRQ, PLA/PLP, RTS, RTI) against the memory bus. It drives the stack-pointer register's dec_SP/inc_SP strobes one access at a time. It presents pulled bytes and a done pulse to the main control FSM.

Parameters:
STACK_PAGE, 8'h01, high address byte of the stack page.
WAIT_LIMIT, 15, max cycles to wait for mem_ready per access before abort (4-bit counter).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
dir  input  1  0 = push, 1 = pull
len  input  2  byte count 1..3; 0 is illegal
push_bytes  input  24  push data; [7:0] written first, then [15:8], then [23:16]
sp  input  8  current SP from stack-pointer register
sp_dec  output  1  one-cycle strobe to the SP register's dec_SP
sp_inc  output  1  one-cycle strobe to the SP register's inc_SP
mem_addr  output  16  stack address
mem_wdata  output  8  write data
mem_we  output  1  write request
mem_re  output  1  read request
mem_rdata  input  8  read data, valid when mem_ready=1
mem_ready  input  1  access accepted/completed this cycle
pull_bytes  output  24  pulled data; first byte read into [7:0]
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on illegal request or timeout

Behaviour:
- Reset, asynchronous, any state: state=IDLE. sp_dec, sp_inc, mem_we, mem_re, busy, done, err all 0. mem_addr=0, mem_wdata=0, pull_bytes=0, internal counters=0.
- States: IDLE, ACCESS, SETTLE, DONE.
- IDLE:
  - start=1 with len!=0: latch dir, len, push_bytes; idx=0; wait counter=0; clear pull_bytes; go to ACCESS.
  - start=1 with len=0: err pulses next cycle; stay IDLE.
  - start is ignored in all other states.
- ACCESS, push: mem_addr={STACK_PAGE,sp}, mem_wdata=byte[idx], mem_we=1.
- ACCESS, pull: mem_addr={STACK_PAGE,sp+1}, with 8-bit wrap (sp=FF gives 0x0100), mem_re=1.
- Request outputs are combinational from state/idx/sp and held stable until mem_ready.
- mem_ready=1 in ACCESS:
  - Same cycle: sp_dec=1 for push, sp_inc=1 for pull.
  - Pull: mem_rdata is captured into pull_bytes byte idx.
  - If idx==len-1, next state is DONE; else idx++ and next state is SETTLE.
- SETTLE: exactly one cycle with no request and no strobe, so the registered SP updates; then ACCESS.
- DONE: done=1 for one cycle, busy stays 1; then IDLE. pull_bytes holds until the next accepted start or reset.
- Timeout: in ACCESS, the wait counter increments each cycle mem_ready=0.
  - When it reaches WAIT_LIMIT, drop the request and go to IDLE with err pulsing one cycle.
  - No SP strobe for the aborted byte. Bytes already completed keep their SP effect. done does not pulse.
  - The counter clears on every accepted access.
- Latency with zero-wait memory (mem_ready=1 in the first ACCESS cycle): 2·len cycles from start acceptance to done, i.e. start, then ACCESS(+SETTLE)…, then DONE.
- SP wraps mod 256 in the SP register: a push at sp=00 writes 0x0100 and SP becomes FF.
- sp_dec and sp_inc are never both 1. Neither strobe is ever high outside ACCESS.
- push_bytes and dir changes after acceptance have no effect on the transaction in flight.

Test Plan:
1. Push len=1: reset, sp=FD, push_bytes=0x0000A5, mem_ready=1 → one write of 0xA5 to 0x01FD, one sp_dec pulse, done 2 cycles after start, busy low afterwards.
2. JSR-style push len=2: sp=FD, push_bytes=0x000034_12 (byte0=0x12, byte1=0x34), SP model decrements on sp_dec → writes 0x12@0x01FD then 0x34@0x01FC, two sp_dec pulses, final SP=FB, done at cycle 4.
3. RTI-style pull len=3: sp=FA, memory 0x01FB=0x24, 0x01FC=0x00, 0x01FD=0xC0, mem_ready delayed 2 cycles per access → reads in that order, pull_bytes=0xC00024, three sp_inc pulses, final SP=FD, one done.
4. Wrap: sp=00 push 0x55 → write 0x0100, SP→FF; then pull len=1 with sp=FF → read 0x0100, pull_bytes[7:0]=0x55, SP→00.
5. Errors: start with len=0 → err pulse, busy stays 0, no bus activity. Push len=2 with mem_ready held 0 → err after WAIT_LIMIT=15 wait cycles, no sp_dec, no done, back in IDLE. start asserted while busy → ignored.
6. Reset mid-operation: assert reset_n=0 during SETTLE of a len=3 push → all outputs zero immediately, IDLE; a new len=1 push after release completes normally.

Source files
------------

// File: rtl/stack_sequencer_if.sv
// Handshake and memory-bus bundle between the 6502 control FSM, the stack
// sequencer, the stack-pointer register and the memory port.
interface stack_sequencer_if;
  logic        start;
  logic        dir;
  logic [1:0]  len;
  logic [23:0] push_bytes;
  logic [7:0]  sp;
  logic        sp_dec;
  logic        sp_inc;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [23:0] pull_bytes;
  logic        busy;
  logic        done;
  logic        err;

  // The sequencer itself is the slave; the control FSM / bench is the master.
  modport slave (
    input  start, dir, len, push_bytes, sp, mem_rdata, mem_ready,
    output sp_dec, sp_inc, mem_addr, mem_wdata, mem_we, mem_re,
           pull_bytes, busy, done, err
  );

  modport master (
    output start, dir, len, push_bytes, sp, mem_rdata, mem_ready,
    input  sp_dec, sp_inc, mem_addr, mem_wdata, mem_we, mem_re,
           pull_bytes, busy, done, err
  );
endinterface

// File: rtl/stack_sequencer.sv
// Sequences 1-3 byte stack pushes/pulls one access at a time, strobing the
// external SP register after each accepted access and reporting done/err.
module stack_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic               clk,
  input logic               reset_n,
  stack_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, SETTLE, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  len_q, len_d;
  logic        dir_q, dir_d;
  logic [23:0] push_q, push_d;
  logic [23:0] pull_q, pull_d;
  logic [3:0]  wait_q, wait_d;
  logic        err_q, err_d;

  logic [7:0]  pushByte;
  logic [7:0]  spPlusOne;

  localparam logic [3:0] WaitLast = 4'(WAIT_LIMIT - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
      push_q  <= '0;
      pull_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      push_q  <= push_d;
      pull_q  <= pull_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    pushByte = 8'h00;
    case (idx_q)
      2'd0:    pushByte = push_q[7:0];
      2'd1:    pushByte = push_q[15:8];
      2'd2:    pushByte = push_q[23:16];
      default: pushByte = 8'h00;
    endcase
  end

  // Pull reads above the current SP; the 8-bit add wraps FF to 00.
  assign spPlusOne = bus.sp + 8'd1;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    dir_d         = dir_q;
    push_d        = push_q;
    pull_d        = pull_q;
    wait_d        = wait_q;
    err_d         = 1'b0;
    bus.sp_dec    = 1'b0;
    bus.sp_inc    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 8'h00;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != 2'd0) begin
            dir_d   = bus.dir;
            len_d   = bus.len;
            push_d  = bus.push_bytes;
            idx_d   = 2'd0;
            wait_d  = 4'd0;
            pull_d  = 24'h000000;
            state_d = ACCESS;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (dir_q) begin
          bus.mem_addr = {STACK_PAGE, spPlusOne};
          bus.mem_re   = 1'b1;
        end else begin
          bus.mem_addr  = {STACK_PAGE, bus.sp};
          bus.mem_wdata = pushByte;
          bus.mem_we    = 1'b1;
        end

        if (bus.mem_ready) begin
          wait_d = 4'd0;
          if (dir_q) begin
            bus.sp_inc = 1'b1;
            case (idx_q)
              2'd0:    pull_d[7:0]   = bus.mem_rdata;
              2'd1:    pull_d[15:8]  = bus.mem_rdata;
              2'd2:    pull_d[23:16] = bus.mem_rdata;
              default: pull_d        = pull_q;
            endcase
          end else begin
            bus.sp_dec = 1'b1;
          end
          if (idx_q == len_q - 2'd1) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = SETTLE;
          end
        end else if (wait_q == WaitLast) begin
          // Abort: earlier bytes keep their SP effect, this one gets none.
          wait_d  = 4'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      SETTLE: state_d = ACCESS;

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = err_q;
  assign bus.pull_bytes = pull_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: models the SP register and a 256-byte
// stack page with configurable ready latency, and checks each step in order.
module tb_stack_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  stack_sequencer_if bus ();

  stack_sequencer #(.STACK_PAGE(8'h01), .WAIT_LIMIT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // SP register, stack memory and bus activity logs.
  logic [7:0]  spReg = 8'h00;
  logic        spLoad = 1'b0;
  logic [7:0]  spLoadVal = 8'h00;
  logic [7:0]  mem [256];
  int          readyDelay = 0;
  int          reqCnt = 0;
  int          decCnt = 0;
  int          incCnt = 0;
  int          doneCnt = 0;
  logic [15:0] wrAddr[$];
  logic [7:0]  wrData[$];
  logic [15:0] rdAddr[$];

  assign bus.sp        = spReg;
  assign bus.mem_ready = (bus.mem_we || bus.mem_re) && (reqCnt >= readyDelay);
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    if (spLoad)          spReg <= spLoadVal;
    else if (bus.sp_dec) spReg <= spReg - 8'd1;
    else if (bus.sp_inc) spReg <= spReg + 8'd1;
    if (bus.mem_we || bus.mem_re) reqCnt <= reqCnt + 1;
    else                          reqCnt <= 0;
    if (bus.mem_we && bus.mem_ready) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      wrAddr.push_back(bus.mem_addr);
      wrData.push_back(bus.mem_wdata);
    end
    if (bus.mem_re && bus.mem_ready) rdAddr.push_back(bus.mem_addr);
    if (bus.sp_dec) decCnt <= decCnt + 1;
    if (bus.sp_inc) incCnt <= incCnt + 1;
    if (bus.done)   doneCnt <= doneCnt + 1;
  end

  int passCnt = 0;
  int totalCnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic setSp(input logic [7:0] v);
    @(negedge clk);
    spLoad = 1'b1;
    spLoadVal = v;
    @(negedge clk);
    spLoad = 1'b0;
  endtask

  task automatic applyStimulus(input logic d, input logic [1:0] l, input logic [23:0] data);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir = d;
    bus.len = l;
    bus.push_bytes = data;
  endtask

  // Cycles from the start strobe to the done pulse; -1 if it never comes.
  task automatic waitDone(input int maxCyc, input bit keepStart, output int lat);
    lat = -1;
    for (int i = 1; i <= maxCyc; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (keepStart) begin
          bus.dir = ~bus.dir;
          bus.len = 2'd3;
          bus.push_bytes = 24'hFFFFFF;
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  int lat;
  int wBase, rBase, dBase, iBase, dnBase;

  initial begin
    bus.start = 1'b0;
    bus.dir = 1'b0;
    bus.len = 2'd0;
    bus.push_bytes = 24'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    checkOutput("rst_we_re", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
    checkOutput("rst_strobes", {30'd0, bus.sp_dec, bus.sp_inc}, 32'd0);
    checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_pull", 32'(bus.pull_bytes), 32'd0);
    reset_n = 1'b1;

    // 1: single push
    setSp(8'hFD);
    wBase = wrAddr.size(); dBase = decCnt;
    applyStimulus(1'b0, 2'd1, 24'h0000A5);
    waitDone(20, 1'b0, lat);
    checkOutput("t1_latency", 32'(lat), 32'd2);
    @(negedge clk);
    checkOutput("t1_busy_after", 32'(bus.busy), 32'd0);
    checkOutput("t1_nwrites", 32'(wrAddr.size() - wBase), 32'd1);
    checkOutput("t1_waddr", 32'(wrAddr[wBase]), 32'h01FD);
    checkOutput("t1_wdata", 32'(wrData[wBase]), 32'hA5);
    checkOutput("t1_decs", 32'(decCnt - dBase), 32'd1);
    checkOutput("t1_sp", 32'(spReg), 32'hFC);

    // 2: two-byte push
    setSp(8'hFD);
    wBase = wrAddr.size(); dBase = decCnt;
    applyStimulus(1'b0, 2'd2, 24'h003412);
    waitDone(20, 1'b0, lat);
    checkOutput("t2_latency", 32'(lat), 32'd4);
    @(negedge clk);
    checkOutput("t2_w0", {wrAddr[wBase], 8'h00, wrData[wBase]}, 32'h01FD_0012);
    checkOutput("t2_w1", {wrAddr[wBase+1], 8'h00, wrData[wBase+1]}, 32'h01FC_0034);
    checkOutput("t2_decs", 32'(decCnt - dBase), 32'd2);
    checkOutput("t2_sp", 32'(spReg), 32'hFB);

    // 3: preload frame with a 3-byte push, then pull it back with slow memory
    setSp(8'hFD);
    applyStimulus(1'b0, 2'd3, 24'h2400C0);
    waitDone(30, 1'b0, lat);
    checkOutput("t3_push_latency", 32'(lat), 32'd6);
    @(negedge clk);
    checkOutput("t3_sp_after_push", 32'(spReg), 32'hFA);
    readyDelay = 2;
    rBase = rdAddr.size(); iBase = incCnt; dnBase = doneCnt;
    applyStimulus(1'b1, 2'd3, 24'h000000);
    waitDone(40, 1'b0, lat);
    checkOutput("t3_pull_latency", 32'(lat), 32'd12);
    @(negedge clk);
    checkOutput("t3_r0", 32'(rdAddr[rBase]), 32'h01FB);
    checkOutput("t3_r1", 32'(rdAddr[rBase+1]), 32'h01FC);
    checkOutput("t3_r2", 32'(rdAddr[rBase+2]), 32'h01FD);
    checkOutput("t3_pull", 32'(bus.pull_bytes), 32'hC00024);
    checkOutput("t3_incs", 32'(incCnt - iBase), 32'd3);
    checkOutput("t3_dones", 32'(doneCnt - dnBase), 32'd1);
    checkOutput("t3_sp", 32'(spReg), 32'hFD);
    readyDelay = 0;

    // 4: SP wrap on push and pull
    setSp(8'h00);
    wBase = wrAddr.size();
    applyStimulus(1'b0, 2'd1, 24'h000055);
    waitDone(20, 1'b0, lat);
    @(negedge clk);
    checkOutput("t4_waddr", 32'(wrAddr[wBase]), 32'h0100);
    checkOutput("t4_sp_ff", 32'(spReg), 32'hFF);
    rBase = rdAddr.size();
    applyStimulus(1'b1, 2'd1, 24'h000000);
    waitDone(20, 1'b0, lat);
    checkOutput("t4_pull_latency", 32'(lat), 32'd2);
    @(negedge clk);
    checkOutput("t4_raddr", 32'(rdAddr[rBase]), 32'h0100);
    checkOutput("t4_pull", 32'(bus.pull_bytes), 32'h000055);
    checkOutput("t4_sp_00", 32'(spReg), 32'h00);

    // 5a: illegal length
    applyStimulus(1'b0, 2'd0, 24'h000011);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("t5_len0_err", 32'(bus.err), 32'd1);
    checkOutput("t5_len0_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_len0_bus", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
    @(negedge clk);
    checkOutput("t5_len0_err_pulse", 32'(bus.err), 32'd0);

    // 5b: timeout with memory never ready
    setSp(8'hFD);
    readyDelay = 1000;
    wBase = wrAddr.size(); dBase = decCnt; dnBase = doneCnt;
    applyStimulus(1'b0, 2'd2, 24'h00BEEF);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.err) begin
        lat = i;
        break;
      end
    end
    checkOutput("t5_timeout_latency", 32'(lat), 32'd16);
    checkOutput("t5_timeout_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_timeout_decs", 32'(decCnt - dBase), 32'd0);
    checkOutput("t5_timeout_dones", 32'(doneCnt - dnBase), 32'd0);
    checkOutput("t5_timeout_writes", 32'(wrAddr.size() - wBase), 32'd0);
    checkOutput("t5_timeout_sp", 32'(spReg), 32'hFD);
    readyDelay = 0;

    // 5c: start held and inputs changed while busy
    setSp(8'hFD);
    wBase = wrAddr.size(); dBase = decCnt; iBase = incCnt; dnBase = doneCnt;
    applyStimulus(1'b0, 2'd2, 24'h007766);
    waitDone(20, 1'b1, lat);
    checkOutput("t5_busy_latency", 32'(lat), 32'd4);
    repeat (2) @(negedge clk);
    checkOutput("t5_busy_idle", 32'(bus.busy), 32'd0);
    checkOutput("t5_busy_writes", 32'(wrAddr.size() - wBase), 32'd2);
    checkOutput("t5_busy_w0", {wrAddr[wBase], 8'h00, wrData[wBase]}, 32'h01FD_0066);
    checkOutput("t5_busy_w1", {wrAddr[wBase+1], 8'h00, wrData[wBase+1]}, 32'h01FC_0077);
    checkOutput("t5_busy_strobes", 32'((decCnt - dBase) * 16 + (incCnt - iBase)), 32'h20);
    checkOutput("t5_busy_dones", 32'(doneCnt - dnBase), 32'd1);

    // 6: asynchronous reset in the middle of a 3-byte push
    setSp(8'hFD);
    applyStimulus(1'b0, 2'd3, 24'h332211);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy_before", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("t6_rst_outs", {27'd0, bus.mem_we, bus.mem_re, bus.sp_dec, bus.done, bus.err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    setSp(8'hF0);
    wBase = wrAddr.size();
    applyStimulus(1'b0, 2'd1, 24'h0000C3);
    waitDone(20, 1'b0, lat);
    checkOutput("t6_latency", 32'(lat), 32'd2);
    @(negedge clk);
    checkOutput("t6_write", {wrAddr[wBase], 8'h00, wrData[wBase]}, 32'h01F0_00C3);
    checkOutput("t6_sp", 32'(spReg), 32'hEF);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
